// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the PC generation stage: default widths, reset vector
// and the state encoding.
package pc_gen_unit_pkg;

    localparam int          PCG_CPU_WIDTH = 64;
    localparam int          PCG_CNT_WIDTH = 64;
    localparam logic [63:0] PCG_RESET_PC  = 64'h8000_0000;

    typedef enum logic [1:0] {
        PCG_BOOT = 2'd0,
        PCG_RUN  = 2'd1,
        PCG_HALT = 2'd2
    } pcg_state_e;

    // Instructions are 4 bytes, so only the two low address bits matter.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: halt > trap > aligned redirect >
// sequential advance > hold, plus the counter enable and misalign condition.
module pc_next_sel
    import pc_gen_unit_pkg::*;
#(
    parameter int W = PCG_CPU_WIDTH
) (
    input  logic         run,
    input  logic [W-1:0] pc,
    input  logic         pc_ready,
    input  logic         redir_valid,
    input  logic [W-1:0] redir_pc,
    input  logic         trap_valid,
    input  logic [W-1:0] trap_pc,
    input  logic         halt,
    output logic [W-1:0] pc_next,
    output logic [W-1:0] pc_seq,
    output logic         cnt_en,
    output logic         misalign_set,
    output logic         go_halt
);

    localparam logic [W-1:0] INSN_BYTES = {{(W-3){1'b0}}, 3'b100};

    logic redir_bad;

    assign pc_seq    = pc + INSN_BYTES;
    assign redir_bad = is_misaligned(redir_pc[1:0]);

    always_comb begin
        pc_next      = pc;
        cnt_en       = 1'b0;
        misalign_set = 1'b0;
        go_halt      = 1'b0;
        if (run) begin
            // While running pc_valid is high, so pc_ready alone is the handshake.
            cnt_en = pc_ready;
            if (halt) begin
                go_halt = 1'b1;
            end else if (trap_valid) begin
                pc_next = trap_pc;
            end else if (redir_valid && !redir_bad) begin
                pc_next = redir_pc;
            end else begin
                misalign_set = redir_valid;
                if (pc_ready) begin
                    pc_next = pc_seq;
                end
            end
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generation stage: holds the fetch PC, hands it to fetch
// over valid/ready, and applies redirects, traps and halt.
module pc_gen_unit
    import pc_gen_unit_pkg::*;
#(
    parameter int                   CPU_WIDTH = PCG_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(PCG_RESET_PC),
    parameter int                   CNT_WIDTH = PCG_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [CPU_WIDTH-1:0] pc,
    output logic                 pc_valid,
    input  logic                 pc_ready,
    output logic [CPU_WIDTH-1:0] snpc,
    input  logic                 redir_valid,
    input  logic [CPU_WIDTH-1:0] redir_pc,
    input  logic                 trap_valid,
    input  logic [CPU_WIDTH-1:0] trap_pc,
    input  logic                 halt,
    output logic                 misalign,
    output logic [CPU_WIDTH-1:0] misalign_addr,
    output logic [CNT_WIDTH-1:0] fetch_cnt,
    output logic                 halted
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    pcg_state_e           state_reg, state_next;
    logic [CPU_WIDTH-1:0] pc_reg;
    logic [CPU_WIDTH-1:0] pc_next;
    logic [CPU_WIDTH-1:0] pc_seq;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 misalign_reg;
    logic [CPU_WIDTH-1:0] misalign_addr_reg;
    logic                 run;
    logic                 cnt_en;
    logic                 misalign_set;
    logic                 go_halt;

    assign run = (state_reg == PCG_RUN);

    pc_next_sel #(
        .W (CPU_WIDTH)
    ) u_next_sel (
        .run          (run),
        .pc           (pc_reg),
        .pc_ready     (pc_ready),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .halt         (halt),
        .pc_next      (pc_next),
        .pc_seq       (pc_seq),
        .cnt_en       (cnt_en),
        .misalign_set (misalign_set),
        .go_halt      (go_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PCG_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // BOOT lasts exactly one cycle; HALT only leaves through reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PCG_BOOT: state_next = PCG_RUN;
            PCG_RUN:  if (go_halt) state_next = PCG_HALT;
            PCG_HALT: state_next = PCG_HALT;
            default:  state_next = PCG_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg            <= RESET_PC;
            cnt_reg           <= '0;
            misalign_reg      <= 1'b0;
            misalign_addr_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= misalign_set;
            if (cnt_en) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
            if (misalign_set) begin
                misalign_addr_reg <= redir_pc;
            end
        end
    end

    assign pc            = pc_reg;
    assign pc_valid      = run;
    assign snpc          = pc_seq;
    assign misalign      = misalign_reg;
    assign misalign_addr = misalign_addr_reg;
    assign fetch_cnt     = cnt_reg;
    assign halted        = (state_reg == PCG_HALT);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: stimulus queues expected fetches, a
// monitor checks each accepted fetch; state checks are made inline.
module tb_pc_gen_unit;

    localparam logic [63:0] RST = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic [63:0] snpc;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic        halt;
    logic        misalign;
    logic [63:0] misalign_addr;
    logic [63:0] fetch_cnt;
    logic        halted;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] cnt;
    } fetch_t;

    fetch_t sb[$];
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .snpc          (snpc),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .halt          (halt),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .fetch_cnt     (fetch_cnt),
        .halted        (halted)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] c);
        fetch_t f;
        f.addr = a;
        f.cnt  = c;
        sb.push_back(f);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pc_valid === 1'b1 && pc_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_fetch", pc, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                fetch_t f;
                f = sb.pop_front();
                chk("fetch_pc", pc, f.addr);
                chk("fetch_cnt", fetch_cnt, f.cnt);
                chk("fetch_snpc", snpc, f.addr + 64'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        pc_ready    = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        trap_valid  = 1'b0;
        trap_pc     = '0;
        halt        = 1'b0;

        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_pc", pc, RST);
        chk("rst_valid", 64'(pc_valid), 64'd0);
        chk("rst_cnt", fetch_cnt, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_misalign_addr", misalign_addr, 64'd0);

        // Release reset; first cycle is BOOT.
        next_cycle();
        rst_n = 1'b1;
        push(RST + 64'h00, 64'd0);
        push(RST + 64'h04, 64'd1);
        push(RST + 64'h08, 64'd2);
        push(RST + 64'h0C, 64'd3);
        @(negedge clk);
        chk("boot_valid", 64'(pc_valid), 64'd0);
        repeat (5) next_cycle();

        // Stall at 8000_0010.
        pc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", pc, RST + 64'h10);
            chk("stall_cnt", fetch_cnt, 64'd4);
            next_cycle();
        end
        pc_ready = 1'b1;
        push(RST + 64'h10, 64'd4);
        next_cycle();

        // Redirect while not ready.
        pc_ready    = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = RST + 64'h100;
        @(negedge clk);
        chk("release_pc", pc, RST + 64'h14);
        next_cycle();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("redir_pc", pc, RST + 64'h100);
        chk("redir_valid_hi", 64'(pc_valid), 64'd1);
        chk("redir_cnt", fetch_cnt, 64'd5);

        // Trap beats redirect.
        trap_valid  = 1'b1;
        trap_pc     = RST + 64'h200;
        redir_valid = 1'b1;
        redir_pc    = RST + 64'h100;
        next_cycle();
        trap_valid  = 1'b0;
        redir_valid = 1'b0;
        @(negedge clk);
        chk("trap_pc", pc, RST + 64'h200);
        chk("trap_cnt", fetch_cnt, 64'd5);

        // Aligned redirect coinciding with a handshake.
        pc_ready    = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = RST + 64'h20;
        push(RST + 64'h200, 64'd5);
        next_cycle();

        // Misaligned redirect with a handshake at 8000_0020.
        redir_pc = RST + 64'h102;
        push(RST + 64'h20, 64'd6);
        @(negedge clk);
        chk("redir_hs_pc", pc, RST + 64'h20);
        chk("misalign_idle", 64'(misalign), 64'd0);
        next_cycle();
        redir_valid = 1'b0;
        push(RST + 64'h24, 64'd7);
        @(negedge clk);
        chk("misalign_pulse", 64'(misalign), 64'd1);
        chk("misalign_addr", misalign_addr, RST + 64'h102);
        chk("misalign_pc", pc, RST + 64'h24);
        next_cycle();
        push(RST + 64'h28, 64'd8);
        @(negedge clk);
        chk("misalign_end", 64'(misalign), 64'd0);
        chk("misalign_hold", misalign_addr, RST + 64'h102);
        next_cycle();
        push(RST + 64'h2C, 64'd9);
        next_cycle();

        // Halt together with a handshake at 8000_0030.
        push(RST + 64'h30, 64'd10);
        halt = 1'b1;
        next_cycle();
        halt        = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = RST + 64'h100;
        trap_valid  = 1'b1;
        trap_pc     = RST + 64'h200;
        @(negedge clk);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_valid", 64'(pc_valid), 64'd0);
        chk("halt_cnt", fetch_cnt, 64'd11);
        chk("halt_pc", pc, RST + 64'h30);
        repeat (2) next_cycle();
        @(negedge clk);
        chk("halt_stay_pc", pc, RST + 64'h30);
        chk("halt_stay", 64'(halted), 64'd1);

        // Asynchronous reset mid-HALT.
        #2;
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        trap_valid  = 1'b0;
        #1;
        chk("rst2_pc", pc, RST);
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_cnt", fetch_cnt, 64'd0);
        chk("rst2_valid", 64'(pc_valid), 64'd0);
        chk("rst2_misalign_addr", misalign_addr, 64'd0);
        next_cycle();
        rst_n       = 1'b1;
        pc_ready    = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = RST + 64'h100;
        @(negedge clk);
        chk("boot2_valid", 64'(pc_valid), 64'd0);
        next_cycle();
        redir_valid = 1'b0;
        trap_valid  = 1'b1;
        trap_pc     = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        chk("boot2_ignored_pc", pc, RST);
        chk("boot2_run_valid", 64'(pc_valid), 64'd1);
        next_cycle();
        trap_valid = 1'b0;
        @(negedge clk);
        chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("top_snpc", snpc, 64'd0);
        pc_ready = 1'b1;
        push(64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        next_cycle();
        pc_ready = 1'b0;
        @(negedge clk);
        chk("wrap_pc", pc, 64'd0);
        chk("wrap_cnt", fetch_cnt, 64'd1);
        next_cycle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
